// File: rtl/audio_mixer_n.sv
// rtl/audio_mixer_n.sv - time-multiplexed N-channel stereo mixer with volume, pan, enable and startup mute
module audio_mixer_n #(
  parameter int              N_CH        = 6,
  parameter int              IN_W        = 8,
  parameter int              OUT_W       = 12,
  parameter int              SHIFT       = 4,
  parameter int              SAMPLE_DIV  = 512,
  parameter int              MUTE_CYCLES = 50000000,
  parameter logic [N_CH-1:0] MUTE_MASK   = '0
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic [N_CH*IN_W-1:0] ch_data,
  input  logic [N_CH*4-1:0]    ch_vol,
  input  logic [N_CH*2-1:0]    ch_pan,
  input  logic [N_CH-1:0]      ch_en,
  input  logic                 mute_restart,
  output logic [OUT_W-1:0]     out_l,
  output logic [OUT_W-1:0]     out_r,
  output logic                 sample_stb,
  output logic                 busy
);
  localparam int TERM_W = IN_W + 4;
  localparam int ACC_W  = TERM_W + $clog2(N_CH);
  localparam int IDX_W  = $clog2(N_CH);
  localparam int TICK_W = $clog2(SAMPLE_DIV);
  localparam int MT_W   = (MUTE_CYCLES > 1) ? $clog2(MUTE_CYCLES + 1) : 1;
  localparam int CMP_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_SCALE} state_t;

  state_t            r_state, w_next;
  logic [TICK_W-1:0] r_tick;
  logic [MT_W-1:0]   r_mute_timer;
  logic [IN_W-1:0]   r_data [N_CH];
  logic [3:0]        r_vol  [N_CH];
  logic [1:0]        r_pan  [N_CH];
  logic [N_CH-1:0]   r_en;
  logic              r_mute;
  logic [IDX_W-1:0]  r_idx;
  logic [ACC_W-1:0]  r_acc_l, r_acc_r;
  logic [OUT_W-1:0]  r_out_l, r_out_r;
  logic              r_stb, r_busy;
  logic              w_start, w_acc_en, w_scale, w_last;
  logic [TERM_W-1:0] w_term;
  logic [CMP_W-1:0]  w_shift_l, w_shift_r;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)                                r_tick <= '0;
    else if (r_tick == TICK_W'(SAMPLE_DIV-1)) r_tick <= '0;
    else                                      r_tick <= r_tick + 1'b1;
  end

  // Restart has priority over the decrement, so a coincident expiry still reloads.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)                    r_mute_timer <= MT_W'(MUTE_CYCLES);
    else if (mute_restart)        r_mute_timer <= MT_W'(MUTE_CYCLES);
    else if (r_mute_timer != '0)  r_mute_timer <= r_mute_timer - 1'b1;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  assign w_last = (r_idx == IDX_W'(N_CH-1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (r_tick == '0) w_next = S_ACC;
      S_ACC:   if (w_last)       w_next = S_SCALE;
      S_SCALE:                   w_next = S_IDLE;
      default:                   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_start  = (r_state == S_IDLE) && (r_tick == '0);
    w_acc_en = (r_state == S_ACC);
    w_scale  = (r_state == S_SCALE);
  end

  assign w_term = (r_en[r_idx] && !(r_mute && MUTE_MASK[r_idx]))
                ? TERM_W'(r_data[r_idx]) * TERM_W'(r_vol[r_idx]) : '0;

  assign w_shift_l = CMP_W'(r_acc_l >> SHIFT);
  assign w_shift_r = CMP_W'(r_acc_r >> SHIFT);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        r_data[i] <= '0;
        r_vol[i]  <= '0;
        r_pan[i]  <= '0;
      end
      r_en    <= '0;
      r_mute  <= 1'b0;
      r_idx   <= '0;
      r_acc_l <= '0;
      r_acc_r <= '0;
      r_out_l <= '0;
      r_out_r <= '0;
      r_stb   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_stb <= 1'b0;
      if (w_start) begin
        for (int i = 0; i < N_CH; i++) begin
          r_data[i] <= ch_data[i*IN_W +: IN_W];
          r_vol[i]  <= ch_vol[i*4 +: 4];
          r_pan[i]  <= ch_pan[i*2 +: 2];
        end
        r_en    <= ch_en;
        r_mute  <= (r_mute_timer != '0);
        r_idx   <= '0;
        r_acc_l <= '0;
        r_acc_r <= '0;
        r_busy  <= 1'b1;
      end
      if (w_acc_en) begin
        if (r_pan[r_idx][0]) r_acc_l <= r_acc_l + ACC_W'(w_term);
        if (r_pan[r_idx][1]) r_acc_r <= r_acc_r + ACC_W'(w_term);
        if (!w_last)         r_idx   <= r_idx + 1'b1;
      end
      if (w_scale) begin
        r_out_l <= (w_shift_l > CMP_W'({OUT_W{1'b1}})) ? {OUT_W{1'b1}} : w_shift_l[OUT_W-1:0];
        r_out_r <= (w_shift_r > CMP_W'({OUT_W{1'b1}})) ? {OUT_W{1'b1}} : w_shift_r[OUT_W-1:0];
        r_stb   <= 1'b1;
        r_busy  <= 1'b0;
      end
    end
  end

  assign out_l      = r_out_l;
  assign out_r      = r_out_r;
  assign sample_stb = r_stb;
  assign busy       = r_busy;
endmodule

// File: tb/tb_audio_mixer_n.sv
// tb/tb_audio_mixer_n.sv - scoreboard bench for audio_mixer_n across shift, saturation and mute variants
module tb_audio_mixer_n;
  localparam int N_CH = 6;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic [47:0] ch_data = '0;
  logic [23:0] ch_vol = '0;
  logic [11:0] ch_pan = '0;
  logic [5:0]  ch_en = '0;
  logic        mute_restart = 1'b0;

  logic [11:0] out_l, out_r, sat_l, sat_r, mut_l, mut_r;
  logic        sample_stb, busy, sat_stb, sat_busy, mut_stb, mut_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {int l; int r; int sl; int sr; int ml; int mr;} exp_t;
  exp_t q[$];

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  audio_mixer_n #(.N_CH(6), .IN_W(8), .OUT_W(12), .SHIFT(4), .SAMPLE_DIV(512),
                  .MUTE_CYCLES(100), .MUTE_MASK(6'b000000)) u_dut (
    .clk_sys(clk_sys), .reset(reset), .ch_data(ch_data), .ch_vol(ch_vol), .ch_pan(ch_pan),
    .ch_en(ch_en), .mute_restart(mute_restart), .out_l(out_l), .out_r(out_r),
    .sample_stb(sample_stb), .busy(busy));

  audio_mixer_n #(.N_CH(6), .IN_W(8), .OUT_W(12), .SHIFT(0), .SAMPLE_DIV(512),
                  .MUTE_CYCLES(100), .MUTE_MASK(6'b000000)) u_sat (
    .clk_sys(clk_sys), .reset(reset), .ch_data(ch_data), .ch_vol(ch_vol), .ch_pan(ch_pan),
    .ch_en(ch_en), .mute_restart(mute_restart), .out_l(sat_l), .out_r(sat_r),
    .sample_stb(sat_stb), .busy(sat_busy));

  audio_mixer_n #(.N_CH(6), .IN_W(8), .OUT_W(12), .SHIFT(4), .SAMPLE_DIV(512),
                  .MUTE_CYCLES(100), .MUTE_MASK(6'b000001)) u_mute (
    .clk_sys(clk_sys), .reset(reset), .ch_data(ch_data), .ch_vol(ch_vol), .ch_pan(ch_pan),
    .ch_en(ch_en), .mute_restart(mute_restart), .out_l(mut_l), .out_r(mut_r),
    .sample_stb(mut_stb), .busy(mut_busy));

  function automatic int model(input int side, input int shift, input bit ch0_muted);
    int sum = 0;
    for (int i = 0; i < N_CH; i++)
      if (ch_en[i] && !(ch0_muted && i == 0) && ch_pan[i*2+side])
        sum += int'(ch_data[i*8 +: 8]) * int'(ch_vol[i*4 +: 4]);
    sum = sum >> shift;
    return (sum > 4095) ? 4095 : sum;
  endfunction

  task automatic push_exp(input bit muted);
    exp_t e;
    e.l  = model(0, 4, 1'b0);
    e.r  = model(1, 4, 1'b0);
    e.sl = model(0, 0, 1'b0);
    e.sr = model(1, 0, 1'b0);
    e.ml = model(0, 4, muted);
    e.mr = model(1, 4, muted);
    q.push_back(e);
  endtask

  task automatic set_ch(input int i, input int d, input int v, input int p, input bit e);
    ch_data[i*8 +: 8] = d[7:0];
    ch_vol[i*4 +: 4]  = v[3:0];
    ch_pan[i*2 +: 2]  = p[1:0];
    ch_en[i]          = e;
  endtask

  task automatic only_ch0;
    for (int i = 1; i < N_CH; i++) set_ch(i, $urandom_range(255), $urandom_range(15), $urandom_range(3), 1'b0);
    set_ch(0, 255, 15, 3, 1'b1);
  endtask

  task automatic wait_stb(input string name);
    exp_t e;
    bit   seen = 0;
    for (int n = 0; n < 600 && !seen; n++) begin
      @(negedge clk_sys);
      if (sample_stb) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s stb_timeout: got no sample_stb, required one within 600 cycles", name);
      if (q.size() > 0) void'(q.pop_front());
      return;
    end
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: got sample_stb, required none (queue empty)", name);
      return;
    end
    e = q.pop_front();
    checks += 7;
    if (out_l !== 12'(e.l))  begin errors++; $display("FAIL %s out_l: got %0d required %0d", name, out_l, e.l); end
    if (out_r !== 12'(e.r))  begin errors++; $display("FAIL %s out_r: got %0d required %0d", name, out_r, e.r); end
    if (sat_l !== 12'(e.sl)) begin errors++; $display("FAIL %s sat_l: got %0d required %0d", name, sat_l, e.sl); end
    if (sat_r !== 12'(e.sr)) begin errors++; $display("FAIL %s sat_r: got %0d required %0d", name, sat_r, e.sr); end
    if (mut_l !== 12'(e.ml)) begin errors++; $display("FAIL %s mute_l: got %0d required %0d", name, mut_l, e.ml); end
    if (mut_r !== 12'(e.mr)) begin errors++; $display("FAIL %s mute_r: got %0d required %0d", name, mut_r, e.mr); end
    if (cyc < 8 || (cyc - 8) % 512 != 0) begin
      errors++; $display("FAIL %s stb_phase: got cycle %0d, required 8+512k", name, cyc);
    end
    checks += 2;
    if (sat_stb !== 1'b1 || mut_stb !== 1'b1) begin
      errors++; $display("FAIL %s stb_align: got sat=%0b mute=%0b required 1 1", name, sat_stb, mut_stb);
    end
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_stb: got %0b required 0", name, busy); end
    @(negedge clk_sys);
    checks++;
    if (sample_stb !== 1'b0) begin errors++; $display("FAIL %s stb_width: got %0b required 0", name, sample_stb); end
  endtask

  task automatic test_reset;
    only_ch0();
    repeat (3) @(negedge clk_sys);
    checks += 4;
    if (out_l !== 12'd0)      begin errors++; $display("FAIL reset out_l: got %0d required 0", out_l); end
    if (out_r !== 12'd0)      begin errors++; $display("FAIL reset out_r: got %0d required 0", out_r); end
    if (sample_stb !== 1'b0)  begin errors++; $display("FAIL reset stb: got %0b required 0", sample_stb); end
    if (busy !== 1'b0)        begin errors++; $display("FAIL reset busy: got %0b required 0", busy); end
    reset = 1'b0;
    push_exp(1'b1);
    wait_stb("first_frame");
  endtask

  task automatic test_basic;
    only_ch0();
    push_exp(1'b0);
    wait_stb("basic_a");
    checks++;
    if (out_l !== 12'd239) begin errors++; $display("FAIL basic_const: got %0d required 239", out_l); end
    push_exp(1'b0);
    wait_stb("basic_b");
  endtask

  task automatic test_pan;
    only_ch0();
    set_ch(0, 255, 15, 3, 1'b0);
    set_ch(1, 100, 8, 1, 1'b1);
    set_ch(2, 200, 15, 2, 1'b1);
    set_ch(3, 77, 0, 3, 1'b1);
    set_ch(4, 90, 9, 0, 1'b1);
    push_exp(1'b0);
    wait_stb("pan");
    checks++;
    if (out_l !== 12'd50 || out_r !== 12'd187) begin
      errors++; $display("FAIL pan_const: got %0d/%0d required 50/187", out_l, out_r);
    end
  endtask

  task automatic test_saturate;
    for (int i = 0; i < N_CH; i++) set_ch(i, 255, 15, 3, 1'b1);
    push_exp(1'b0);
    wait_stb("saturate");
    checks++;
    if (sat_l !== 12'd4095 || sat_r !== 12'd4095) begin
      errors++; $display("FAIL sat_const: got %0d/%0d required 4095/4095", sat_l, sat_r);
    end
  endtask

  task automatic test_mute_restart;
    only_ch0();
    push_exp(1'b1);
    repeat (448) @(negedge clk_sys);
    mute_restart = 1'b1;
    @(negedge clk_sys);
    mute_restart = 1'b0;
    wait_stb("mute_restart");
    push_exp(1'b0);
    wait_stb("mute_expired");
  endtask

  task automatic test_snapshot;
    only_ch0();
    push_exp(1'b0);
    repeat (506) @(negedge clk_sys);
    ch_data[7:0] = 8'd0;
    push_exp(1'b0);
    wait_stb("snapshot_held");
    wait_stb("snapshot_next");
  endtask

  task automatic test_reset_mid_frame;
    only_ch0();
    repeat (505) @(negedge clk_sys);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL acc_busy: got %0b required 1", busy); end
    reset = 1'b1;
    #1;
    checks += 3;
    if (out_l !== 12'd0 || out_r !== 12'd0) begin
      errors++; $display("FAIL abort_out: got %0d/%0d required 0/0", out_l, out_r);
    end
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b required 0", busy); end
    if (sample_stb !== 1'b0) begin errors++; $display("FAIL abort_stb: got %0b required 0", sample_stb); end
    repeat (10) begin
      @(negedge clk_sys);
      checks++;
      if (sample_stb !== 1'b0) begin errors++; $display("FAIL abort_no_stb: got %0b required 0", sample_stb); end
    end
    reset = 1'b0;
    push_exp(1'b1);
    wait_stb("after_abort");
    push_exp(1'b0);
    wait_stb("after_abort_unmuted");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pan();
    test_saturate();
    test_mute_restart();
    test_snapshot();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
